// File: rtl/inception_a_seq_pkg.sv
// Shared types and constants for the Inception-ResNet-A channel-pass sequencer.
// Holds the sequencer state encoding, kernel word offsets per branch and width helpers.
package inception_a_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN,
      ST_NEXT
   } seq_state_t;

   // First kernel word of each conv branch inside the flat kernel bank
   localparam int X0_OFF = 0;
   localparam int X1_OFF = 1;
   localparam int X2_OFF = 2;
   localparam int X3_OFF = 11;
   localparam int X4_OFF = 12;
   localparam int X5_OFF = 21;
   localparam int X7_OFF = 30;
   localparam int KW_WORDS = X7_OFF + 1;

   // Width of a counter that must hold the value n itself
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int branch_off(input int b);
      case (b)
         0:       return X0_OFF;
         1:       return X1_OFF;
         2:       return X2_OFF;
         3:       return X3_OFF;
         4:       return X4_OFF;
         5:       return X5_OFF;
         default: return X7_OFF;
      endcase
   endfunction

endpackage

// File: rtl/inception_a_seq_wload.sv
// Kernel weight loader: walks the weight ROM for one channel and fills the flat kernel bank.
// ROM data returns one cycle after the read, so word idx-1 is written while idx is issued.
module inception_a_wload
   import inception_a_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_W      = 31,
   parameter int CH_W       = 9,
   parameter int AW         = 14
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load_en,
   input  logic [CH_W-1:0]             ch,
   input  logic [DATA_WIDTH-1:0]       wt_data,
   output logic                        wt_rd,
   output logic [AW-1:0]               wt_addr,
   output logic                        load_last,
   output logic [NUM_W*DATA_WIDTH-1:0] kernel_bank
);

   localparam int IDX_W = cnt_width(NUM_W);

   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx <= '0;
      end else if (!load_en) begin
         idx <= '0;
      end else if (idx != IDX_W'(NUM_W)) begin
         idx <= idx + IDX_W'(1);
      end
   end

   assign wt_rd     = load_en && (idx != IDX_W'(NUM_W));
   assign wt_addr   = wt_rd ? (AW'(ch) * AW'(NUM_W) + AW'(idx)) : '0;
   assign load_last = load_en && (idx == IDX_W'(NUM_W));

   // The bank is only written during LOAD, so it holds the kernel for the whole pass
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kernel_bank <= '0;
      end else if (load_en && (idx != '0)) begin
         kernel_bank[(int'(idx) - 1) * DATA_WIDTH +: DATA_WIDTH] <= wt_data;
      end
   end

endmodule

// File: rtl/inception_a_seq.sv
// Channel-pass sequencer: per channel load kernels, stream one IMG x IMG plane, drain results.
// Optional drain watchdog enabled by defining INCEPTION_A_SEQ_TIMEOUT_EN.
module inception_a_seq
   import inception_a_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMG        = 35,
   parameter int NUM_CH     = 320,
   parameter int NUM_W      = KW_WORDS
`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = 4096
`endif
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              err,
   output logic                              wt_rd,
   output logic [$clog2(NUM_CH*NUM_W)-1:0]   wt_addr,
   input  logic [DATA_WIDTH-1:0]             wt_data,
   output logic [NUM_W*DATA_WIDTH-1:0]       kernel_bank,
   input  logic                              src_valid,
   output logic                              src_ready,
   input  logic [DATA_WIDTH-1:0]             src_data,
   output logic                              dp_clear,
   output logic                              dp_valid_in,
   output logic [DATA_WIDTH-1:0]             dp_pxl_in,
   input  logic                              dp_valid_out,
   input  logic [DATA_WIDTH-1:0]             dp_pxl_out,
   output logic                              out_valid,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              out_last
);

   localparam int PIX   = IMG * IMG;
   localparam int CNT_W = cnt_width(PIX);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW    = $clog2(NUM_CH * NUM_W);

   seq_state_t       state;
   logic [CH_W-1:0]  ch;
   logic [CNT_W-1:0] pix_cnt;
   logic [CNT_W-1:0] res_cnt;
   logic             load_last;
   logic             src_hs;
   logic             counting;

   assign src_ready = (state == ST_STREAM);
   assign dp_clear  = (state == ST_LOAD);
   assign src_hs    = src_valid && src_ready;
   assign counting  = (state == ST_STREAM) || (state == ST_DRAIN);

   inception_a_wload #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_W      (NUM_W),
      .CH_W       (CH_W),
      .AW         (AW)
   ) u_wload (
      .clk         (clk),
      .reset       (reset),
      .load_en     (dp_clear),
      .ch          (ch),
      .wt_data     (wt_data),
      .wt_rd       (wt_rd),
      .wt_addr     (wt_addr),
      .load_last   (load_last),
      .kernel_bank (kernel_bank)
   );

`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
   localparam int WD_W = cnt_width(TIMEOUT);
   logic [WD_W-1:0] wd_cnt;
`else
   assign err = 1'b0;
`endif

   // Pass sequencing; res_cnt runs in STREAM too because results overlap the plane
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         ch      <= '0;
         pix_cnt <= '0;
         res_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
         err     <= 1'b0;
         wd_cnt  <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_LOAD;
                  ch      <= '0;
                  pix_cnt <= '0;
                  res_cnt <= '0;
                  busy    <= 1'b1;
`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
                  err     <= 1'b0;
`endif
               end
            end
            ST_LOAD: begin
               if (load_last) state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (src_hs) begin
                  pix_cnt <= pix_cnt + CNT_W'(1);
                  if (pix_cnt == CNT_W'(PIX - 1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (res_cnt == CNT_W'(PIX)) begin
                  state <= ST_NEXT;
               end
`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
               else if (dp_valid_out) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            ST_NEXT: begin
               if (ch == CH_W'(NUM_CH - 1)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state   <= ST_LOAD;
                  ch      <= ch + CH_W'(1);
                  pix_cnt <= '0;
                  res_cnt <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (counting && dp_valid_out && (res_cnt != CNT_W'(PIX))) begin
            res_cnt <= res_cnt + CNT_W'(1);
         end
`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
         if (state != ST_DRAIN) wd_cnt <= '0;
`endif
      end
   end

   // One-cycle registered forwarding in both directions; out_last tags the final result of the run
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_valid_in <= 1'b0;
         dp_pxl_in   <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
      end else begin
         dp_valid_in <= src_hs;
         if (src_hs) dp_pxl_in <= src_data;
         out_valid <= dp_valid_out;
         out_data  <= dp_pxl_out;
         out_last  <= counting && dp_valid_out && (res_cnt == CNT_W'(PIX - 1))
                      && (ch == CH_W'(NUM_CH - 1));
      end
   end

endmodule

// File: tb/tb_inception_a_seq.sv
// Directed bench for inception_a_seq with IMG=4, NUM_CH=2 and a ROM holding word value = addr.
// A small datapath model echoes pixels XOR a key after a selectable latency.
module tb_inception_a_seq;
   import inception_a_seq_pkg::*;

   localparam int DW = 32;
   localparam logic [31:0] RES_KEY = 32'h5A5A_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, err;
   logic          wt_rd;
   logic [5:0]    wt_addr;
   logic [DW-1:0] wt_data = '0;
   logic [31*DW-1:0] kernel_bank;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [DW-1:0] src_data = '0;
   logic          dp_clear, dp_valid_in;
   logic [DW-1:0] dp_pxl_in;
   logic          dp_valid_out;
   logic [DW-1:0] dp_pxl_out;
   logic          out_valid, out_last;
   logic [DW-1:0] out_data;

   int vec_cnt = 0;
   int miscompares = 0;

   inception_a_seq #(
      .DATA_WIDTH (DW),
      .IMG        (4),
      .NUM_CH     (2),
      .NUM_W      (31)
`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT    (8)
`endif
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .wt_rd        (wt_rd),
      .wt_addr      (wt_addr),
      .wt_data      (wt_data),
      .kernel_bank  (kernel_bank),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_data     (src_data),
      .dp_clear     (dp_clear),
      .dp_valid_in  (dp_valid_in),
      .dp_pxl_in    (dp_pxl_in),
      .dp_valid_out (dp_valid_out),
      .dp_pxl_out   (dp_pxl_out),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   // Weight ROM: data = address, one cycle after the read strobe
   always @(posedge clk) wt_data <= wt_rd ? DW'(wt_addr) : '0;

   // Datapath model with selectable latency; dp_en=0 models a dead datapath
   int            lat = 1;
   logic          dp_en = 1'b1;
   logic [7:0]    vpipe = '0;
   logic [DW-1:0] dpipe [8];
   always @(posedge clk) begin
      vpipe <= {vpipe[6:0], dp_valid_in & dp_en};
      dpipe[0] <= dp_pxl_in ^ RES_KEY;
      for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
   end
   assign dp_valid_out = vpipe[lat-1];
   assign dp_pxl_out   = dpipe[lat-1];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Monitor / source state, sampled 2 time units after each rising edge
   logic mon_en = 1'b0;
   logic run_src = 1'b0;
   int   src_mode = 0;
   logic tog = 1'b1;
   logic prev_hs = 1'b0, prev_clear = 1'b0, prev_ready = 1'b0;
   logic [DW-1:0] prev_pxl = '0;
   int   cyc = 0, pix_sent = 0, pass_idx = -1, clr_run = 0;
   int   out_cnt = 0, out_last_at = 0, out_last_cyc = 0, done_cnt = 0, done_cyc = 0;
   int   last_res_cyc = 0;
   int   vin_per_pass [4], res_per_pass [4], clear_len [4], gap_after [4];

   task automatic clearStats();
      pix_sent = 0; pass_idx = -1; clr_run = 0; out_cnt = 0; out_last_at = 0;
      out_last_cyc = 0; done_cnt = 0; done_cyc = 0; last_res_cyc = 0; tog = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vin_per_pass[i] = 0; res_per_pass[i] = 0; clear_len[i] = 0; gap_after[i] = 0;
      end
   endtask

   always @(posedge clk) begin
      logic bank_ok;
      logic in_rng;
      #2;
      cyc++;
      if (mon_en) begin
         checkOutput("dp_vin_mirror", dp_valid_in, prev_hs);
         if (prev_hs) checkOutput("dp_pxl_mirror", dp_pxl_in, prev_pxl);
         if (dp_clear && !prev_clear) begin
            if (pass_idx >= 0 && pass_idx < 4) gap_after[pass_idx] = cyc - last_res_cyc;
            pass_idx++;
         end
         in_rng = (pass_idx >= 0) && (pass_idx < 4);
         if (dp_clear) clr_run++;
         else if (prev_clear) begin
            if (in_rng) clear_len[pass_idx] = clr_run;
            clr_run = 0;
         end
         if (src_ready && !prev_ready && in_rng) begin
            bank_ok = 1'b1;
            for (int w = 0; w < 31; w++)
               if (kernel_bank[w*DW +: DW] !== DW'(pass_idx*31 + w)) bank_ok = 1'b0;
            checkOutput("kbank_all", bank_ok, 1'b1);
            checkOutput("kword5", kernel_bank[5*DW +: DW], (pass_idx == 0) ? 5 : 36);
            checkOutput("kword_x5", kernel_bank[branch_off(5)*DW +: DW], (pass_idx == 0) ? 21 : 52);
         end
         if (dp_valid_in && in_rng) vin_per_pass[pass_idx]++;
         if (dp_valid_out && in_rng) begin
            res_per_pass[pass_idx]++;
            last_res_cyc = cyc;
         end
         if (out_valid) begin
            checkOutput("out_data", out_data, DW'(out_cnt) ^ RES_KEY);
            out_cnt++;
         end
         if (out_last) begin
            out_last_at = out_cnt;
            out_last_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      prev_clear = dp_clear;
      prev_ready = src_ready;
      if (run_src) begin
         src_valid = (src_mode == 0) ? 1'b1 : tog;
         tog = ~tog;
      end else begin
         src_valid = 1'b0;
      end
      src_data = DW'(pix_sent);
      prev_hs  = src_valid && src_ready;
      prev_pxl = src_data;
      if (prev_hs) pix_sent++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int mode, input int latency);
      src_mode = mode;
      lat = latency;
      clearStats();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic waitIdle(input int max_cyc);
      int n = 0;
      while (busy === 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      checkOutput("run_bound", busy, 1'b0);
      step();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: got hang, expected finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int n;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_wt_rd", wt_rd, 0);
      checkOutput("rst_wt_addr", wt_addr, 0);
      checkOutput("rst_src_ready", src_ready, 0);
      checkOutput("rst_dp_clear", dp_clear, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_kbank_zero", |kernel_bank, 0);
      mon_en = 1'b1;
      run_src = 1'b1;

      $display("[TB] basic run");
      applyStimulus(0, 1);
      checkOutput("busy_after_start", busy, 1);
      checkOutput("clear_after_start", dp_clear, 1);
      checkOutput("first_rd_addr", wt_addr, 0);
      waitIdle(400);
      checkOutput("basic_pixels", pix_sent, 32);
      checkOutput("basic_done_cnt", done_cnt, 1);
      checkOutput("basic_out_cnt", out_cnt, 32);
      checkOutput("basic_last_idx", out_last_at, 32);
      checkOutput("basic_done_after_last", done_cyc - out_last_cyc, 2);
      checkOutput("basic_clear_len0", clear_len[0], 32);
      checkOutput("basic_clear_len1", clear_len[1], 32);
      checkOutput("basic_err", err, 0);

      $display("[TB] backpressure gaps");
      applyStimulus(1, 1);
      waitIdle(600);
      checkOutput("gap_vin_pass0", vin_per_pass[0], 16);
      checkOutput("gap_vin_pass1", vin_per_pass[1], 16);
      checkOutput("gap_pixels", pix_sent, 32);
      checkOutput("gap_done_cnt", done_cnt, 1);

      $display("[TB] early results, latency 3");
      applyStimulus(0, 3);
      waitIdle(400);
      checkOutput("early_res_pass0", res_per_pass[0], 16);
      checkOutput("early_res_pass1", res_per_pass[1], 16);
      checkOutput("early_drain_exit", gap_after[0], 3);
      checkOutput("early_last_idx", out_last_at, 32);
      checkOutput("early_done_cnt", done_cnt, 1);

      $display("[TB] start while busy");
      applyStimulus(0, 1);
      n = 0;
      while (src_ready !== 1'b1 && n < 100) begin step(); n++; end
      checkOutput("sb_reach_stream", src_ready, 1);
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      waitIdle(400);
      checkOutput("sb_pixels", pix_sent, 32);
      checkOutput("sb_done_cnt", done_cnt, 1);
      checkOutput("sb_passes", pass_idx, 1);
      checkOutput("sb_clear_len0", clear_len[0], 32);

      $display("[TB] reset mid-LOAD");
      applyStimulus(0, 1);
      repeat (4) step();
      checkOutput("mid_load_clear", dp_clear, 1);
      checkOutput("mid_load_kbank_set", |kernel_bank, 1);
      reset = 1'b1;
      step();
      checkOutput("mrst_busy", busy, 0);
      checkOutput("mrst_dp_clear", dp_clear, 0);
      checkOutput("mrst_wt_rd", wt_rd, 0);
      checkOutput("mrst_wt_addr", wt_addr, 0);
      checkOutput("mrst_kbank_zero", |kernel_bank, 0);
      reset = 1'b0;
      step();
      applyStimulus(0, 1);
      waitIdle(400);
      checkOutput("post_rst_pixels", pix_sent, 32);
      checkOutput("post_rst_done_cnt", done_cnt, 1);
      checkOutput("post_rst_last_idx", out_last_at, 32);

`ifdef INCEPTION_A_SEQ_TIMEOUT_EN
      $display("[TB] drain watchdog");
      dp_en = 1'b0;
      applyStimulus(0, 1);
      n = 0;
      while (src_ready !== 1'b1 && n < 100) begin step(); n++; end
      while (src_ready === 1'b1 && n < 200) begin step(); n++; end
      checkOutput("wd_reach_drain", src_ready, 0);
      repeat (7) step();
      checkOutput("wd_err_before", err, 0);
      checkOutput("wd_busy_before", busy, 1);
      step();
      checkOutput("wd_err_trip", err, 1);
      checkOutput("wd_busy_trip", busy, 0);
      repeat (10) step();
      checkOutput("wd_no_done", done_cnt, 0);
      checkOutput("wd_err_sticky", err, 1);
      applyStimulus(0, 1);
      checkOutput("wd_err_cleared", err, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      dp_en = 1'b1;
      step();
`endif

      run_src = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule

// File: doc/inception_a_seq.md
# inception_a_seq

Channel-pass sequencer for the Inception-ResNet-A streaming datapath. For each input channel it performs three steps. First, it loads that channel's NUM_W kernel words from a weight memory into a flat kernel register bank that drives every conv kernel input of the datapath. Second, it streams one IMG×IMG plane from the upstream source into the datapath. Third, it waits until the datapath has produced IMG×IMG results before starting the next channel. It sits between the feature-map buffer / weight ROM and the Inception-ResNet-A block, and raises done after NUM_CH passes.

## Interface
- DATA_WIDTH, 32, pixel/weight word width
- IMG, 35, plane side length (pixels per pass = IMG*IMG)
- NUM_CH, 320, channel passes per run
- NUM_W, 31, kernel words per channel (1+1+9+1+9+9+1)
- TIMEOUT, 4096, drain watchdog limit in cycles (used only with the macro)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after final result of final channel
- err  out  1  sticky watchdog flag, cleared by next accepted start
- wt_rd  out  1  weight read strobe
- wt_addr  out  clog2(NUM_CH*NUM_W)  weight address = ch*NUM_W + idx
- wt_data  in  DATA_WIDTH  weight data, valid 1 cycle after wt_rd
- kernel_bank  out  NUM_W*DATA_WIDTH  word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_valid / src_ready / src_data  in/out/in  1/1/DATA_WIDTH  upstream pixel handshake
- dp_clear  out  1  datapath clear, high throughout LOAD
- dp_valid_in / dp_pxl_in  out  1/DATA_WIDTH  to datapath valid_in / pxl_in
- dp_valid_out / dp_pxl_out  in  1/DATA_WIDTH  from datapath valid_out / pxl_out
- out_valid / out_data / out_last  out  1/DATA_WIDTH/1  result stream to sink

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, NEXT.
- IDLE:
  - start=1 → LOAD with ch=0, busy=1, err cleared.
  - start while busy is ignored.
- LOAD:
  - Issues wt_rd with idx 0..NUM_W-1 on consecutive cycles.
  - wt_data captured into kernel word idx-1 the following cycle.
  - Exits to STREAM after NUM_W+1 cycles, with all words written.
- STREAM:
  - src_ready=1.
  - Each src_valid&src_ready increments pix_cnt.
  - Registered forward to the datapath: dp_valid_in and dp_pxl_in equal the previous cycle's handshake and data.
  - When pix_cnt reaches IMG*IMG-1 with a handshake → DRAIN.
- DRAIN:
  - src_ready=0.
  - Exits → NEXT when res_cnt reaches IMG*IMG.
- res_cnt:
  - Counts dp_valid_out in STREAM and DRAIN, because results begin before streaming ends.
  - Cleared on entering LOAD.
- NEXT:
  - ch==NUM_CH-1 → IDLE, done=1, busy=0.
  - Otherwise → LOAD with ch+1.
- Result path:
  - out_valid/out_data register dp_valid_out/dp_pxl_out (1 cycle).
  - out_last marks the IMG*IMG-th result of channel NUM_CH-1.
  - The sink has no backpressure.
- Unexpected inputs:
  - dp_valid_out outside STREAM/DRAIN is forwarded but not counted.
  - Results beyond IMG*IMG within a pass are ignored by the counter.
- kernel_bank holds its value outside LOAD.

## Timing
- Reset:
  - All outputs 0, kernel_bank 0, state IDLE, counters 0.
  - Reset mid-run aborts immediately; no done is produced.
- Pixel forward latency: 1 cycle. Result forward latency: 1 cycle.
- Per-pass minimum duration: (NUM_W+1) + IMG*IMG + drain + 1 cycles.
- Arithmetic:
  - pix_cnt/res_cnt are clog2(IMG*IMG+1) bits; ch is clog2(NUM_CH) bits.
  - No wrap occurs within a pass; counters clear at LOAD.
- dp_clear is high for exactly the NUM_W+1 LOAD cycles.

## Configuration
- INCEPTION_A_SEQ_TIMEOUT_EN defined:
  - A watchdog counts consecutive DRAIN cycles without dp_valid_out.
  - On reaching TIMEOUT: err=1, busy=0, return to IDLE, no done.
- Undefined: no watchdog, err tied 0, DRAIN waits indefinitely.

## Structure
- Shared package holds the state enum, the NUM_W per-branch word offsets (x0=0, x1=1, x2=2, x3=11, x4=12, x5=21, x7=30), and clog2 helper constants.
- One sub-module: inception_a_wload (LOAD address generator plus kernel register bank), instantiated once.

## Test plan
Use IMG=4, NUM_CH=2, NUM_W=31 with a ROM holding word value = addr.
- Basic run: start, src_valid always high.
  - kernel word 5 = 5 in pass 0, = 36 in pass 1.
  - 32 pixels accepted; done pulses once, after out_last.
- Backpressure gaps: src_valid toggled every other cycle.
  - dp_valid_in mirrors accepted beats 1 cycle later.
  - Exactly 16 dp_valid_in per pass.
- Early results: datapath model with 3-cycle latency (results overlap STREAM).
  - Each pass exits DRAIN after exactly 16 results.
  - out_last coincides with the 32nd out_valid.
- Start while busy: second start pulse mid-STREAM.
  - No restart; pix_cnt unaffected.
  - Single done.
- Reset mid-LOAD:
  - All outputs 0 next cycle, kernel_bank 0.
  - A following start runs cleanly.
- Watchdog (macro on, TIMEOUT=8): datapath model never responds.
  - err=1 and busy=0 eight cycles into DRAIN; no done.
